// File: rtl/a24bit_lane_acc_if.sv
// Beat/result bundle for the three-lane 24-bit partial-sum accumulator.
// Latency: n/a (wires only).
// Backpressure: none; the source may present one beat every cycle.
// Signals: I_valid/I_data/I_first/I_last carry a beat toward the accumulator;
//          O_valid/O_lane/O_sum carry a finished lane total back,
//          O_lane_ptr shows which lane the next valid beat will land on.
interface a24bit_lane_acc_if;
  logic        I_valid;
  logic [23:0] I_data;
  logic        I_first;
  logic        I_last;
  logic        O_valid;
  logic [1:0]  O_lane;
  logic [23:0] O_sum;
  logic [1:0]  O_lane_ptr;

  // Beat source / result sink.
  modport master (
    output I_valid, I_data, I_first, I_last,
    input  O_valid, O_lane, O_sum, O_lane_ptr
  );

  // The accumulator itself.
  modport slave (
    input  I_valid, I_data, I_first, I_last,
    output O_valid, O_lane, O_sum, O_lane_ptr
  );
endinterface

// File: rtl/a24bit_lane_acc.sv
// Three-lane interleaved 24-bit accumulator, 8-bit byte-sliced carry pipeline.
// Latency: beat sampled at edge k -> result/O_valid registered at edge k+3.
// Backpressure: none; one beat accepted per cycle unconditionally.
// Ports: I_clk clock; I_rst synchronous active-high reset;
//        bus (a24bit_lane_acc_if.slave) beat in, lane total out, lane pointer.
// Optional feature macro ACC_SAT_EN: saturate lane totals at 24'hFFFFFF with
// a sticky per-lane overflow flag; undefined means plain modulo-2^24 wrap.
module a24bit_lane_acc (
  input  logic              I_clk,
  input  logic              I_rst,
  a24bit_lane_acc_if.slave  bus
);

  // Round-robin lane pointer and per-lane accumulators.
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q [3];

  // Fetch stage: full operands plus beat tags.
  logic        f_vld_q, f_last_q;
  logic [1:0]  f_lane_q;
  logic [23:0] f_a_q, f_b_q;

  // Stage 1: byte0 sum (with carry); bytes 1..2 of both operands delayed.
  logic        s1_vld_q, s1_last_q;
  logic [1:0]  s1_lane_q;
  logic [8:0]  s1_lo_q;
  logic [15:0] s1_a_q, s1_b_q;

  // Stage 2: byte1 sum (with carry); byte2 of both operands delayed.
  logic        s2_vld_q, s2_last_q;
  logic [1:0]  s2_lane_q;
  logic [7:0]  s2_lo_q;
  logic [8:0]  s2_mid_q;
  logic [7:0]  s2_a_q, s2_b_q;

  // Registered result port.
  logic        o_vld_q;
  logic [1:0]  o_lane_q;
  logic [23:0] o_sum_q;

  // Stage-3 result and accumulator read path.
  logic [23:0] res_d;
  logic [23:0] acc_sel;
  logic        byp;
  logic [23:0] b_d;

`ifdef ACC_SAT_EN
  logic [2:0]  ov_q;
  logic        f_ov_q, s1_ov_q, s2_ov_q;
  logic [8:0]  hi_sum;
  logic        ov_d, ov_sel, ov_b_d;

  assign hi_sum = {1'b0, s2_a_q} + {1'b0, s2_b_q} + {8'd0, s2_mid_q[8]};
  // A carry out of byte2, or any earlier overflow in this frame, pins the total.
  assign ov_d   = s2_ov_q | hi_sum[8];
  assign res_d  = ov_d ? 24'hFFFFFF : {hi_sum[7:0], s2_mid_q[7:0], s2_lo_q};
`else
  logic [7:0]  hi_sum;

  // Carry out of byte2 is dropped: modulo-2^24 accumulation.
  assign hi_sum = s2_a_q + s2_b_q + {7'd0, s2_mid_q[8]};
  assign res_d  = {hi_sum, s2_mid_q[7:0], s2_lo_q};
`endif

  // Lane L is reused no sooner than 3 cycles later, which is exactly when its
  // previous beat leaves stage 3; forward that result instead of stale acc.
  assign byp = s2_vld_q && (s2_lane_q == lane_q);

  always_comb begin
    acc_sel = acc_q[0];
    case (lane_q)
      2'd1:    acc_sel = acc_q[1];
      2'd2:    acc_sel = acc_q[2];
      default: acc_sel = acc_q[0];
    endcase
  end

  assign b_d    = bus.I_first ? 24'd0 : (byp ? res_d : acc_sel);
  assign lane_d = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;

`ifdef ACC_SAT_EN
  always_comb begin
    ov_sel = ov_q[0];
    case (lane_q)
      2'd1:    ov_sel = ov_q[1];
      2'd2:    ov_sel = ov_q[2];
      default: ov_sel = ov_q[0];
    endcase
  end

  // A first beat restarts the flag; its own carry (if any) is added in stage 3.
  assign ov_b_d = bus.I_first ? 1'b0 : (byp ? ov_d : ov_sel);
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      lane_q    <= 2'd0;
      f_vld_q   <= 1'b0;
      f_last_q  <= 1'b0;
      f_lane_q  <= 2'd0;
      f_a_q     <= 24'd0;
      f_b_q     <= 24'd0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_lane_q <= 2'd0;
      s1_lo_q   <= 9'd0;
      s1_a_q    <= 16'd0;
      s1_b_q    <= 16'd0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_lane_q <= 2'd0;
      s2_lo_q   <= 8'd0;
      s2_mid_q  <= 9'd0;
      s2_a_q    <= 8'd0;
      s2_b_q    <= 8'd0;
      o_vld_q   <= 1'b0;
      o_lane_q  <= 2'd0;
      o_sum_q   <= 24'd0;
      for (int i = 0; i < 3; i++) acc_q[i] <= 24'd0;
`ifdef ACC_SAT_EN
      ov_q      <= 3'd0;
      f_ov_q    <= 1'b0;
      s1_ov_q   <= 1'b0;
      s2_ov_q   <= 1'b0;
`endif
    end else begin
      // Fetch
      f_vld_q <= bus.I_valid;
      if (bus.I_valid) begin
        lane_q   <= lane_d;
        f_lane_q <= lane_q;
        f_last_q <= bus.I_last;
        f_a_q    <= bus.I_data;
        f_b_q    <= b_d;
`ifdef ACC_SAT_EN
        f_ov_q   <= ov_b_d;
`endif
      end

      // Stage 1
      s1_vld_q  <= f_vld_q;
      s1_last_q <= f_last_q;
      s1_lane_q <= f_lane_q;
      s1_lo_q   <= {1'b0, f_a_q[7:0]} + {1'b0, f_b_q[7:0]};
      s1_a_q    <= f_a_q[23:8];
      s1_b_q    <= f_b_q[23:8];

      // Stage 2
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_lane_q <= s1_lane_q;
      s2_lo_q   <= s1_lo_q[7:0];
      s2_mid_q  <= {1'b0, s1_a_q[7:0]} + {1'b0, s1_b_q[7:0]} + {8'd0, s1_lo_q[8]};
      s2_a_q    <= s1_a_q[15:8];
      s2_b_q    <= s1_b_q[15:8];
`ifdef ACC_SAT_EN
      s1_ov_q   <= f_ov_q;
      s2_ov_q   <= s1_ov_q;
`endif

      // Stage 3: write-back and result register
      o_vld_q <= s2_vld_q && s2_last_q;
      if (s2_vld_q) begin
        for (int i = 0; i < 3; i++) begin
          if (s2_lane_q == 2'(i)) begin
            acc_q[i] <= res_d;
`ifdef ACC_SAT_EN
            ov_q[i]  <= ov_d;
`endif
          end
        end
        if (s2_last_q) begin
          o_lane_q <= s2_lane_q;
          o_sum_q  <= res_d;
        end
      end
    end
  end

  assign bus.O_valid    = o_vld_q;
  assign bus.O_lane     = o_lane_q;
  assign bus.O_sum      = o_sum_q;
  assign bus.O_lane_ptr = lane_q;

endmodule

// File: doc/a24bit_lane_acc.md
# a24bit_lane_acc

Three-lane interleaved 24-bit partial-sum accumulator, downstream of the 24-bit byte-sliced pipelined adder stage. It accepts a stream of 24-bit partial sums, round-robined over three independent lanes. Each lane is accumulated through an internal three-stage byte-sliced carry pipeline (8 bits per stage), so the feedback latency equals the lane count. A lane's total is emitted on its frame's last beat, toward quantisation / write-back.

## Interface
Parameters:
- none (width 24, 3 lanes, 8-bit slices fixed)

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset, synchronous, active-high
- I_valid  in  1  input beat valid
- I_data  in  24  unsigned partial sum
- I_first  in  1  first beat of the current lane's frame; accumulator treated as 0
- I_last  in  1  last beat of the current lane's frame; result emitted
- O_valid  out  1  result valid, one-cycle pulse per last beat
- O_lane  out  2  lane of result (0..2)
- O_sum  out  24  lane total
- O_lane_ptr  out  2  lane the next valid beat goes to

## Operation
- Lane pointer (S_lane) starts at 0 and advances 0→1→2→0 only on accepted beats (I_valid=1); gaps do not advance it.
- Fetch (edge k, beat valid):
  - S_a <= I_data.
  - S_b <= 0 if I_first, else the lane's accumulator (with bypass).
  - Lane, first and last tags travel with the beat.
- Stage 1 (edge k+1): byte0 sum, 9 bits.
- Stage 2 (edge k+2): byte1 + carry0.
- Stage 3 (edge k+3):
  - byte2 + carry1.
  - The assembled 24-bit result is written to acc[lane].
  - Carry out of byte2 is discarded (mod 2^24), except under ACC_SAT_EN.
- Upper bytes are delay-aligned exactly as slices require. No operand mixing between beats.
- Bypass:
  - A beat fetching lane L in the same cycle that stage 3 completes lane L uses the stage-3 result, not acc[L].
  - Lane reuse is ≥3 cycles apart, so this is the only hazard.
- Output, registered with write-back at edge k+3:
  - If last: O_valid=1, O_lane=lane, O_sum=result.
  - Otherwise O_valid=0 and O_sum/O_lane hold their previous values.
- first and last on the same beat: result = I_data, emitted.
- Beat without first on a lane never started: adds to the stored acc value (0 after reset).
- No backpressure; the block accepts one beat per cycle unconditionally.

## Timing
- Latency: beat sampled at edge k → O_valid high after edge k+3, for one cycle.
- Throughput: 1 beat/cycle sustained, any valid gap pattern.
- Reset, synchronous on I_rst=1 at an edge:
  - Stage valids, acc[0..2], S_lane = 0.
  - O_valid=0, O_lane=0, O_sum=0, O_lane_ptr=0.
- Reset mid-operation discards all in-flight beats; no O_valid is produced for them.
- I_valid=1 together with I_rst=1: the beat is dropped.
- Inputs are ignored when I_valid=0; I_first and I_last are don't-care.

## Configuration
- ACC_SAT_EN defined:
  - Each lane keeps a sticky overflow flag, set on byte2 carry-out and cleared by a first beat (which reinitialises it from the new beat's own carry).
  - While the flag is set or a carry occurs, stage-3 result and O_sum = 24'hFFFFFF.
  - The bypass path carries the flag too.
- Undefined: pure modulo-2^24 wrap, no flag logic.

## Test plan
- Single lane: reset, then 3 beats (lanes 0,1,2) first+last with 0x0000FF, 0x00FF01, 0x123456 → O_valid at edges +3,+4,+5; O_lane 0,1,2; O_sum 0x0000FF, 0x00FF01, 0x123456.
- Back-to-back carry chain: 6 continuous beats, lanes 0,1,2,0,1,2.
  - Lane 0 gets 0x00FFFF (first) then 0x000001 (last) → 0x010000, exercising bypass.
  - Lanes 1 and 2 get 1+2 → 3.
- Valid gaps: same beats as the back-to-back case with I_valid=0 cycles between them → identical sums; lanes stay aligned with O_lane_ptr.
- Wrap: lane 0 0xFFFFFF (first) + 0x000002 (last) → 0x000001 without ACC_SAT_EN, 0xFFFFFF with it. A following first+last beat of 5 → 5.
- Reset mid-frame: I_rst one cycle after a last beat → no O_valid. Then a fresh first+last beat of 7 → lane 0, O_sum 7, after 3 cycles.
- Random: 10k beats with random valid/first/last compared against a 3-lane reference model, in both configurations.
